// File: rtl/fp_cmp_seq.sv
// Sequencer for the double-precision FP compare unit: gathers two even/odd register pairs
// over the 32-bit FP read port, latches the compare result into FCC, and resolves bc1t/bc1f.
// Optional build macro FCMP_BYPASS_EN: resolve a waiting branch from cmp_cond during CMP.
module fp_cmp_seq #(
   parameter int RA_W = 5,
   parameter int DW   = 32
) (
   input  logic              clk,
   input  logic              reset,
   input  logic              start,
   input  logic [RA_W-1:0]   fs,
   input  logic [RA_W-1:0]   ft,
   input  logic [3:0]        aluop,
   output logic              ready,
   output logic              busy,
   output logic              done,
   output logic              err,
   output logic [RA_W-1:0]   rf_raddr,
   input  logic [DW-1:0]     rf_rdata,
   output logic [2*DW-1:0]   cmp_a,
   output logic [2*DW-1:0]   cmp_b,
   output logic [3:0]        cmp_aluop,
   output logic              cmp_double,
   input  logic              cmp_cond,
   input  logic              br_req,
   input  logic              br_tf,
   output logic              br_stall,
   output logic              br_taken,
   output logic              fcc
);

   typedef enum logic [2:0] {
      S_IDLE,
      S_RA0,
      S_RA1,
      S_RB0,
      S_RB1,
      S_CMP
   } state_e;

   state_e            state_q, state_d;
   logic [RA_W-1:0]   fs_q, ft_q;
   logic [3:0]        aluop_q;
   logic [2*DW-1:0]   cmp_a_q, cmp_b_q;
   logic              fcc_q, done_q, err_q;

   logic              idle;
   logic              accept;
   logic              reject;

   assign idle   = (state_q == S_IDLE);
   // Double operands live in even/odd pairs, so an odd base register is malformed.
   assign accept = idle && start && !fs[0] && !ft[0];
   assign reject = idle && start && (fs[0] || ft[0]);

   // State register
   // NOTE: sequential state uses non-blocking assignments so every register samples
   // pre-edge values, independent of statement order.
   always_ff @(posedge clk) begin
      if (reset) begin
         state_q <= S_IDLE;
      end else begin
         state_q <= state_d;
      end
   end

   // Next-state logic
   always_comb begin
      // NOTE: default first, so no path through the case leaves state_d unassigned (no latch).
      state_d = state_q;
      case (state_q)
         S_IDLE:  if (accept) state_d = S_RA0;
         S_RA0:   state_d = S_RA1;
         S_RA1:   state_d = S_RB0;
         S_RB0:   state_d = S_RB1;
         S_RB1:   state_d = S_CMP;
         S_CMP:   state_d = S_IDLE;
         default: state_d = S_IDLE;
      endcase
   end

   // Request latch, operand gather and condition flag
   // NOTE: datapath registers are reset too, so cmp_a/cmp_b/cmp_aluop read 0 after reset
   // and an aborted sequence cannot leak a half-loaded operand.
   always_ff @(posedge clk) begin
      if (reset) begin
         fs_q    <= '0;
         ft_q    <= '0;
         aluop_q <= '0;
         cmp_a_q <= '0;
         cmp_b_q <= '0;
         fcc_q   <= 1'b0;
         done_q  <= 1'b0;
         err_q   <= 1'b0;
      end else begin
         done_q <= (state_q == S_CMP);
         err_q  <= reject;
         if (accept) begin
            fs_q    <= fs;
            ft_q    <= ft;
            aluop_q <= aluop;
         end
         case (state_q)
            S_RA0:   cmp_a_q[DW-1:0]    <= rf_rdata;
            S_RA1:   cmp_a_q[2*DW-1:DW] <= rf_rdata;
            S_RB0:   cmp_b_q[DW-1:0]    <= rf_rdata;
            S_RB1:   cmp_b_q[2*DW-1:DW] <= rf_rdata;
            S_CMP:   fcc_q              <= cmp_cond;
            default: ;
         endcase
      end
   end

   // Output logic
   always_comb begin
      ready    = idle;
      busy     = !idle;
      rf_raddr = '0;
      case (state_q)
         S_RA0:   rf_raddr = fs_q;
         S_RA1:   rf_raddr = fs_q + RA_W'(1);
         S_RB0:   rf_raddr = ft_q;
         S_RB1:   rf_raddr = ft_q + RA_W'(1);
         default: rf_raddr = '0;
      endcase
`ifdef FCMP_BYPASS_EN
      // In CMP the operands are complete, so the live compare result can resolve the branch.
      br_stall = br_req && ((busy && (state_q != S_CMP)) || (idle && start));
      br_taken = (state_q == S_CMP) ? (cmp_cond == br_tf) : (fcc_q == br_tf);
`else
      // A branch issued alongside start is younger than the compare and must wait for it.
      br_stall = br_req && (busy || (idle && start));
      br_taken = (fcc_q == br_tf);
`endif
   end

   assign done       = done_q;
   assign err        = err_q;
   assign fcc        = fcc_q;
   assign cmp_a      = cmp_a_q;
   assign cmp_b      = cmp_b_q;
   assign cmp_aluop  = aluop_q;
   assign cmp_double = 1'b1;

endmodule
